// File: rtl/mcfg_pkg.sv
// Shared types and helpers for the multi-channel frame generator.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package mcfg_pkg;

    // Run-control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Default widths
    localparam int N_CH_DEF     = 4;
    localparam int N_CH_MAX     = 16;
    localparam int PERIOD_W_DEF = 32;
    localparam int CNT_W_DEF    = 8;

    // Minimum legal period length in clocks
    localparam int PERIOD_MIN   = 2;

    // LSB position of channel 'ch' inside a packed per-channel bus of 'width'-bit fields
    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/mcfg_ch_cmp.sv
// One channel: latches its offset/width at run start and drives a registered pulse while the shared counter sits in [offset, offset+width).
// Latency: 1 clock from counter value to o_pulse.
// Backpressure: none; i_en low forces the next output low.
module mcfg_ch_cmp #(
    parameter int PERIOD_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_latch,
    input  logic [PERIOD_W-1:0] i_start_off,
    input  logic [PERIOD_W-1:0] i_width,
    input  logic [PERIOD_W-1:0] i_cnt,
    input  logic                i_en,
    output logic                o_pulse
);

    logic [PERIOD_W-1:0] r_off;
    logic [PERIOD_W:0]   r_end;   // one extra bit so offset+width never wraps
    logic                r_pulse;
    logic                w_hit;

    // Window compare. Zero width gives r_end == r_off, so it never hits.
    // The counter never exceeds period-1, which clips the window at period end
    // and makes an offset at or beyond the period unreachable.
    assign w_hit = (i_cnt >= r_off) && ({1'b0, i_cnt} < r_end);

    // Capture this channel's window once per accepted start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_off <= '0;
            r_end <= '0;
        end else if (i_latch) begin
            r_off <= i_start_off;
            r_end <= {1'b0, i_start_off} + {1'b0, i_width};
        end
    end

    // Registered pulse output
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= i_en & w_hit;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/multi_ch_frame_gen.sv
// N_CH gated pulse trains sharing one period counter; runs cnt_nums periods per start edge then raises sticky done. Optional macro: MCFG_CONTINUOUS_EN (cnt_nums==0 runs until stop).
// Latency: busy/frame_idx 1 clock after the sampled start edge; ref_signal 1 clock after the counter value it reflects.
// Backpressure: none; stop aborts a run on the next clock, start edges during a run are ignored.
module multi_ch_frame_gen
    import mcfg_pkg::*;
#(
    parameter int N_CH     = N_CH_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                       ref_clk_200m,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic [CNT_W-1:0]           cnt_nums,
    input  logic [PERIOD_W-1:0]        sig_period,
    input  logic [N_CH*PERIOD_W-1:0]   sig_start,
    input  logic [N_CH*PERIOD_W-1:0]   duty_cycle,
    output logic [N_CH-1:0]            ref_signal,
    output logic [CNT_W-1:0]           frame_idx,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err
);

    localparam logic [PERIOD_W-1:0] ONE_P = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(PERIOD_MIN);
    localparam logic [CNT_W-1:0]    ONE_C = CNT_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_start_d;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] r_period_m1;
    logic [CNT_W-1:0]    r_frame_idx;
    logic [CNT_W-1:0]    r_cnt_nums;

    logic                w_edge;
    logic                w_accept;
    logic                w_nums_ok;
    logic                w_cfg_ok;
    logic                w_latch;
    logic                w_period_end;
    logic                w_last_frame;
    logic                w_run_hold;

    // A start edge is only meaningful outside RUN, and stop wins over it
    assign w_edge   = start & ~r_start_d;
    assign w_accept = w_edge & ~stop & (r_state != ST_RUN);

`ifdef MCFG_CONTINUOUS_EN
    // cnt_nums == 0 selects an endless run
    assign w_nums_ok    = 1'b1;
    assign w_last_frame = (r_cnt_nums != '0) && (r_frame_idx == (r_cnt_nums - ONE_C));
`else
    assign w_nums_ok    = (cnt_nums != '0);
    assign w_last_frame = (r_frame_idx == (r_cnt_nums - ONE_C));
`endif

    assign w_cfg_ok     = (sig_period >= MIN_P) && w_nums_ok;
    assign w_latch      = w_accept & w_cfg_ok;
    assign w_period_end = (r_cnt == r_period_m1);

    // Channels only produce a pulse when the run continues into the next clock;
    // this suppresses the final-compare tail on completion and on abort.
    assign w_run_hold   = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);

    // Start-edge history register
    always_ff @(posedge ref_clk_200m or negedge reset_n) begin
        if (!reset_n) begin
            r_start_d <= 1'b0;
        end else begin
            r_start_d <= start;
        end
    end

    // FSM state register
    always_ff @(posedge ref_clk_200m or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: launch/reject on start edge, finish after last period, abort on stop
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (w_accept) begin
                    w_state_nxt = w_cfg_ok ? ST_RUN : ST_ERR;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_period_end && w_last_frame) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch run configuration on an accepted start; period-1 is computed once here
    always_ff @(posedge ref_clk_200m or negedge reset_n) begin
        if (!reset_n) begin
            r_period_m1 <= '0;
            r_cnt_nums  <= '0;
        end else if (w_latch) begin
            r_period_m1 <= sig_period - ONE_P;
            r_cnt_nums  <= cnt_nums;
        end
    end

    // Period counter and frame index; frame_idx wraps naturally at 2^CNT_W
    always_ff @(posedge ref_clk_200m or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_frame_idx <= '0;
        end else if (w_latch) begin
            r_cnt       <= '0;
            r_frame_idx <= '0;
        end else if (w_run_hold) begin
            if (w_period_end) begin
                r_cnt       <= '0;
                r_frame_idx <= r_frame_idx + ONE_C;
            end else begin
                r_cnt       <= r_cnt + ONE_P;
            end
        end
    end

    // Per-channel window comparators
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        mcfg_ch_cmp #(
            .PERIOD_W (PERIOD_W)
        ) u_ch (
            .i_clk       (ref_clk_200m),
            .i_rst_n     (reset_n),
            .i_latch     (w_latch),
            .i_start_off (sig_start[ch_lsb(gi, PERIOD_W) +: PERIOD_W]),
            .i_width     (duty_cycle[ch_lsb(gi, PERIOD_W) +: PERIOD_W]),
            .i_cnt       (r_cnt),
            .i_en        (w_run_hold),
            .o_pulse     (ref_signal[gi])
        );
    end

    // Status outputs decode directly from the registered state
    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign cfg_err   = (r_state == ST_ERR);
    assign frame_idx = r_frame_idx;

endmodule

// File: tb/tb_multi_ch_frame_gen.sv
// Directed plus randomized bench for multi_ch_frame_gen with a closed-form reference model.
module tb_multi_ch_frame_gen;

    localparam int N_CH = 4;
    localparam int PW   = 32;
`ifdef MCFG_CONTINUOUS_EN
    localparam int CW   = 2;
`else
    localparam int CW   = 8;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 stop;
    logic [CW-1:0]        cnt_nums;
    logic [PW-1:0]        sig_period;
    logic [N_CH*PW-1:0]   sig_start;
    logic [N_CH*PW-1:0]   duty_cycle;
    logic [N_CH-1:0]      ref_signal;
    logic [CW-1:0]        frame_idx;
    logic                 busy;
    logic                 done;
    logic                 cfg_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int cfg_s [N_CH];
    int cfg_w [N_CH];

    always #5 clk = ~clk;

    multi_ch_frame_gen #(
        .N_CH     (N_CH),
        .PERIOD_W (PW),
        .CNT_W    (CW)
    ) dut (
        .ref_clk_200m (clk),
        .reset_n      (rst_n),
        .start        (start),
        .stop         (stop),
        .cnt_nums     (cnt_nums),
        .sig_period   (sig_period),
        .sig_start    (sig_start),
        .duty_cycle   (duty_cycle),
        .ref_signal   (ref_signal),
        .frame_idx    (frame_idx),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel i is high for period positions c with s_i <= c < s_i + w_i
    function automatic logic [N_CH-1:0] exp_ref(input int c);
        logic [N_CH-1:0] v;
        v = '0;
        for (int i = 0; i < N_CH; i++)
            if (c >= cfg_s[i] && c < cfg_s[i] + cfg_w[i]) v[i] = 1'b1;
        return v;
    endfunction

    task automatic apply_cfg(input int n, input int p);
        cnt_nums   = CW'(n);
        sig_period = PW'(p);
        for (int i = 0; i < N_CH; i++) begin
            sig_start[i*PW +: PW]  = PW'(cfg_s[i]);
            duty_cycle[i*PW +: PW] = PW'(cfg_w[i]);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic exp_done, input logic exp_err);
        check({tag, ".ref"},  ref_signal, '0);
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".done"}, done, exp_done);
        check({tag, ".err"},  cfg_err, exp_err);
    endtask

    // mode 0: run to completion; 1: stop after cycle abort_k; 2: reset after cycle abort_k.
    // Cycle k=1 is the first clock after the start edge was sampled.
    task automatic run(input string tag, input int n, input int p, input int mode,
                       input int abort_k, input bit hold, input int chg_k);
        int last_k;
        int total;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        apply_cfg(n, p);
        start  = 1'b1;
        total  = n * p;
        last_k = (mode == 0) ? total + 1 : abort_k;
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (n == 0 || k <= total) begin
                check({tag, ".busy"},  busy, 1'b1);
                check({tag, ".done"},  done, 1'b0);
                check({tag, ".err"},   cfg_err, 1'b0);
                check({tag, ".frame"}, frame_idx, ((k - 1) / p) % (1 << CW));
                check({tag, ".ref"},   ref_signal, (k == 1) ? '0 : exp_ref((k - 2) % p));
            end else begin
                check_idle_outputs({tag, ".end"}, 1'b1, 1'b0);
                check({tag, ".end.frame"}, frame_idx, n - 1);
            end
            if (k == chg_k) begin
                sig_period = PW'(3);
                cnt_nums   = CW'(1);
            end
        end
        if (mode == 1) begin
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            check_idle_outputs({tag, ".stop"}, 1'b0, 1'b0);
            check({tag, ".stop.frame"}, frame_idx, ((abort_k - 1) / p) % (1 << CW));
        end else if (mode == 2) begin
            rst_n = 1'b0;
            #1;
            check_idle_outputs({tag, ".arst"}, 1'b0, 1'b0);
            check({tag, ".arst.frame"}, frame_idx, 0);
            @(negedge clk);
            rst_n = 1'b1;
        end
        start = 1'b0;
    endtask

    // A start with an invalid configuration must land in the error state
    task automatic run_err(input string tag, input int n, input int p);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        apply_cfg(n, p);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_idle_outputs(tag, 1'b0, 1'b1);
        @(negedge clk);
        check_idle_outputs({tag, ".hold"}, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        cnt_nums   = '0;
        sig_period = '0;
        sig_start  = '0;
        duty_cycle = '0;
        #3;
        check_idle_outputs("reset", 1'b0, 1'b0);
        check("reset.frame", frame_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reference configuration: windows 0-2, 2-3, 5-9, 9 (clipped)
        cfg_s = '{0, 2, 5, 9};
        cfg_w = '{3, 2, 5, 4};
        run("basic", 2, 10, 0, 0, 1'b0, 0);

        // Period below minimum is rejected; a good start clears the error
        run_err("per1", 2, 1);
        run("recover", 1, 8, 0, 0, 1'b0, 0);

`ifdef MCFG_CONTINUOUS_EN
        // Endless run: frame index wraps 0,1,2,3,0,1 before stop
        run("cont", 0, 3, 1, 16, 1'b0, 0);
`else
        run_err("nums0", 0, 10);
`endif

        // Start held high and config changed mid-run: no retrigger, old config kept
        run("hold", 2, 10, 0, 0, 1'b1, 3);

        // Stop while in frame 1 at count 4
        run("stop", 2, 10, 1, 15, 1'b0, 0);

        // Asynchronous reset while channel 2 is high, then a clean run
        run("arst", 2, 10, 2, 7, 1'b0, 0);
        run("post_arst", 1, 10, 0, 0, 1'b0, 0);

        // Randomized configurations including zero widths and offsets past the period
        for (int r = 0; r < 8; r++) begin
            int p;
            int n;
            p = $urandom_range(12, 2);
            n = $urandom_range(3, 1);
            for (int i = 0; i < N_CH; i++) begin
                cfg_s[i] = $urandom_range(p + 1, 0);
                cfg_w[i] = $urandom_range(p, 0);
            end
            run("rand", n, p, 0, 0, 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
